// File: rtl/complex_stream_mux_nto1.sv
// N-to-1 complex sample selector with one output pipeline register and valid/ready handshake.
// Channel choice is static (sel) or round-robin with a fixed burst per channel.
module complex_stream_mux_nto1 #(
    parameter int WL    = 14,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*(WL+1)-1:0]   in_real,
    input  logic [N*(WL+1)-1:0]   in_imag,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WL:0]           out_real,
    output logic [WL:0]           out_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_last
);

    localparam int              W        = WL + 1;
    localparam logic [7:0]      CNT_LAST = 8'(BURST - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);
    localparam logic [SELW:0]   N_L      = (SELW + 1)'(N);

    logic [SELW-1:0] r_cur_ch;
    logic [7:0]      r_cnt;
    logic            r_mode_q;
    logic [WL:0]     r_out_real;
    logic [WL:0]     r_out_imag;
    logic            r_out_valid;
    logic [SELW-1:0] r_out_ch;
    logic            r_out_last;

    logic [WL:0]     w_sel_real;
    logic [WL:0]     w_sel_imag;
    logic            w_sel_valid;
    logic            w_can_load;
    logic            w_accept;
    logic            w_mode_chg;
    logic            w_burst_end;
    logic            w_last;
    logic            w_sel_ok;
    logic [SELW-1:0] w_ch_next;

    always_comb begin
        w_sel_real  = '0;
        w_sel_imag  = '0;
        w_sel_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (r_cur_ch == SELW'(k)) begin
                w_sel_real  = in_real[k*W +: W];
                w_sel_imag  = in_imag[k*W +: W];
                w_sel_valid = in_valid[k];
            end
        end
    end

    assign w_can_load  = !r_out_valid || out_ready;
    assign w_accept    = w_sel_valid && w_can_load;
    assign w_mode_chg  = mode != r_mode_q;
    // Burst accounting follows the mode of the previous cycle, so a switching-edge accept counts under the old mode.
    assign w_burst_end = r_mode_q && (r_cnt == CNT_LAST);
    assign w_last      = w_accept && w_burst_end;
    assign w_sel_ok    = {1'b0, sel} < N_L;
    assign w_ch_next   = (r_cur_ch == CH_LAST) ? '0 : r_cur_ch + 1'b1;

    // Gated with rst_n so no channel is offered a slot while reset is held.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && w_can_load && (r_cur_ch == SELW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ch    <= '0;
            r_cnt       <= '0;
            r_mode_q    <= 1'b0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_mode_q <= mode;

            if (w_accept) begin
                r_out_real  <= w_sel_real;
                r_out_imag  <= w_sel_imag;
                r_out_ch    <= r_cur_ch;
                r_out_last  <= w_last;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (!mode) begin
                r_cnt <= '0;
                if (w_sel_ok) begin
                    r_cur_ch <= sel;
                end else if (w_last) begin
                    r_cur_ch <= w_ch_next;
                end
            end else if (w_mode_chg) begin
                // Entering round-robin: rotation starts from wherever static mode left off.
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_burst_end) begin
                    r_cnt    <= '0;
                    r_cur_ch <= w_ch_next;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_complex_stream_mux_nto1.sv
// Directed bench: instance A (N=4, BURST=8) for static select and backpressure,
// instance B (N=3, BURST=4) for round-robin rotation, stalls, out-of-range select and reset.
module tb_complex_stream_mux_nto1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [59:0] a_real, a_imag;
    logic [3:0]  a_valid, a_ready;
    logic        a_mode, a_ordy, a_ov, a_olast;
    logic [1:0]  a_sel, a_och;
    logic [14:0] a_oreal, a_oimag;

    logic [44:0] b_real, b_imag;
    logic [2:0]  b_valid, b_ready;
    logic        b_mode, b_ordy, b_ov, b_olast;
    logic [1:0]  b_sel, b_och;
    logic [14:0] b_oreal, b_oimag;

    complex_stream_mux_nto1 #(.WL(14), .N(4), .SELW(2), .BURST(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_real(a_real), .in_imag(a_imag),
        .in_valid(a_valid), .in_ready(a_ready), .mode(a_mode), .sel(a_sel),
        .out_real(a_oreal), .out_imag(a_oimag), .out_valid(a_ov), .out_ready(a_ordy),
        .out_ch(a_och), .out_last(a_olast)
    );

    complex_stream_mux_nto1 #(.WL(14), .N(3), .SELW(2), .BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_real(b_real), .in_imag(b_imag),
        .in_valid(b_valid), .in_ready(b_ready), .mode(b_mode), .sel(b_sel),
        .out_real(b_oreal), .out_imag(b_oimag), .out_valid(b_ov), .out_ready(b_ordy),
        .out_ch(b_och), .out_last(b_olast)
    );

    logic [14:0] A_RE [4] = '{15'h1234, 15'h0111, 15'h7FFF, 15'h0ABC};
    logic [14:0] A_IM [4] = '{15'h7FFF, 15'h0222, 15'h4000, 15'h5555};
    logic [14:0] B_RE [3] = '{15'h0100, 15'h0101, 15'h0102};
    logic [14:0] B_IM [3] = '{15'h7000, 15'h7001, 15'h7002};

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_irdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic       exp_last;
    } vec_t;

    vec_t tbl [11];
    int   n_checks = 0;
    int   n_err    = 0;
    int   EXP_CH [13]   = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int   EXP_LAST [13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string name, input int ch, input logic last);
        chk({name, "_ov"}, 64'(b_ov), 64'd1);
        chk({name, "_ch"}, 64'(b_och), 64'(ch));
        chk({name, "_last"}, 64'(b_olast), 64'(last));
        chk({name, "_re"}, 64'(b_oreal), 64'(B_RE[ch]));
        chk({name, "_im"}, 64'(b_oimag), 64'(B_IM[ch]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[5]  = '{1'b0, 2'd3, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[8]  = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
        tbl[9]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            a_real = 60'({$urandom(), $urandom()});
            a_imag = 60'({$urandom(), $urandom()});
            a_valid = 4'($urandom()); a_mode = 1'($urandom()); a_sel = 2'($urandom());
            a_ordy = 1'($urandom());
            b_real = 45'({$urandom(), $urandom()});
            b_imag = 45'({$urandom(), $urandom()});
            b_valid = 3'($urandom()); b_mode = 1'($urandom()); b_sel = 2'($urandom());
            b_ordy = 1'($urandom());
            #1;
            chk("rst_a_out", 64'({a_ov, a_oreal, a_oimag, a_och, a_olast}), 64'd0);
            chk("rst_b_out", 64'({b_ov, b_oreal, b_oimag, b_och, b_olast}), 64'd0);
            chk("rst_ready", 64'({a_ready, b_ready}), 64'd0);
            step();
        end

        for (int k = 0; k < 4; k++) begin
            a_real[k*15 +: 15] = A_RE[k];
            a_imag[k*15 +: 15] = A_IM[k];
        end
        for (int k = 0; k < 3; k++) begin
            b_real[k*15 +: 15] = B_RE[k];
            b_imag[k*15 +: 15] = B_IM[k];
        end
        a_valid = '0; a_mode = 1'b0; a_sel = '0; a_ordy = 1'b1;
        b_valid = '0; b_mode = 1'b0; b_sel = '0; b_ordy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Static-select table on instance A
        for (int i = 0; i < 11; i++) begin
            a_mode = tbl[i].mode; a_sel = tbl[i].sel; a_valid = tbl[i].valid; a_ordy = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_irdy", i), 64'(a_ready), 64'(tbl[i].exp_irdy));
            step();
            chk($sformatf("tbl%0d_ov", i), 64'(a_ov), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_ch", i), 64'(a_och), 64'(tbl[i].exp_ch));
            chk($sformatf("tbl%0d_last", i), 64'(a_olast), 64'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_re", i), 64'(a_oreal), 64'(A_RE[tbl[i].exp_ch]));
            chk($sformatf("tbl%0d_im", i), 64'(a_oimag), 64'(A_IM[tbl[i].exp_ch]));
        end

        // Backpressure: ch2 sample (7FFF/4000) held for 5 cycles while inputs change
        a_ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_real[30 +: 15] = 15'(16'h0100 + i);
            a_imag[30 +: 15] = 15'(16'h0200 + i);
            #1;
            chk($sformatf("bp%0d_irdy", i), 64'(a_ready), 64'd0);
            step();
            chk($sformatf("bp%0d_hold", i), 64'({a_ov, a_och, a_olast, a_oreal, a_oimag}),
                64'({1'b1, 2'd2, 1'b0, 15'h7FFF, 15'h4000}));
        end
        a_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_real[30 +: 15] = 15'(16'h3000 + i);
            a_imag[30 +: 15] = 15'(16'h2000 + i);
            #1;
            chk($sformatf("b2b%0d_irdy", i), 64'(a_ready), 64'b0100);
            step();
            chk($sformatf("b2b%0d_out", i), 64'({a_ov, a_och, a_oreal, a_oimag}),
                64'({1'b1, 2'd2, 15'(16'h3000 + i), 15'(16'h2000 + i)}));
        end
        a_valid = '0;

        // Round-robin wrap on instance B; mode change cycle with no data
        b_mode = 1'b1; b_valid = 3'b000;
        #1;
        chk("rr_start_irdy", 64'(b_ready), 64'b001);
        step();
        chk("rr_start_ov", 64'(b_ov), 64'd0);
        b_valid = 3'b111;
        for (int i = 0; i < 13; i++) begin
            step();
            chk_b($sformatf("rr%0d", i + 1), EXP_CH[i], 1'(EXP_LAST[i]));
        end

        // ch1 idle: finish ch0 burst, then rotation must wait on ch1
        b_valid = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b($sformatf("rr_fin%0d", i), 0, i == 2);
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("stall%0d_irdy", i), 64'(b_ready), 64'b010);
            step();
            chk($sformatf("stall%0d_ov", i), 64'(b_ov), 64'd0);
        end
        b_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b($sformatf("resume%0d", i), 1, i == 3);
        end

        // Back to static: sel takes over on the switching edge, then out-of-range sel holds
        b_mode = 1'b0; b_sel = 2'd1;
        #1;
        chk("sw_irdy", 64'(b_ready), 64'b100);
        step();
        chk_b("sw", 2, 1'b0);
        b_sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("oor%0d_irdy", i), 64'(b_ready), 64'b010);
            step();
            chk_b($sformatf("oor%0d", i), 1, 1'b0);
        end

        // Reset mid-burst: two ch1 beats, then reset
        b_mode = 1'b1; b_valid = 3'b000;
        step();
        chk("mb_idle_ov", 64'(b_ov), 64'd0);
        b_valid = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_b($sformatf("mb%0d", i), 1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mb_rst_ov", 64'(b_ov), 64'd0);
        chk("mb_rst_irdy", 64'(b_ready), 64'd0);
        b_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mb_rel_ov", 64'(b_ov), 64'd0);
        b_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_b($sformatf("post%0d", i), (i < 4) ? 0 : 1, i == 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
